// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants: write-back select encodings, control bit positions and register ids.
package mips32_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_RSV  = 2'b11;

  localparam int CTL_REGWRITE = 0;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Decoded MEM/WB control bundle.
  typedef struct packed {
    logic       regWrite;
    logic [1:0] wbSel;
  } wb_ctl_t;

  function automatic wb_ctl_t decodeCtl(input logic [0:2] ctl);
    wb_ctl_t c;
    c.regWrite = ctl[CTL_REGWRITE];
    c.wbSel    = ctl[1:2];
    return c;
  endfunction

endpackage

// File: rtl/wb_regfile_mux.sv
// Write-back source selection; the reserved encoding falls back to the ALU result.
module wb_mux
  import mips32_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LINK_OFS = 0
) (
  input  logic [1:0]        wbSel,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] memData,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] wbData
);

  always_comb begin
    wbData = aluResult;
    case (wbSel)
      WB_SEL_MEM:  wbData = memData;
      WB_SEL_LINK: wbData = pc + DATA_W'(LINK_OFS);
      default:     wbData = aluResult;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back mux, 32x32 register file, two async read ports.
// Define WB_BYPASS_EN to forward the same-cycle write-back onto matching read ports.
module wb_regfile
  import mips32_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int LINK_OFS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:2]           controlIn,
  input  logic [DATA_W-1:0]    pcIn,
  input  logic [DATA_W-1:0]    memDataIn,
  input  logic [DATA_W-1:0]    aluResultIn,
  input  logic [REG_AW-1:0]    destRegIn,
  input  logic [REG_AW-1:0]    readReg1,
  input  logic [REG_AW-1:0]    readReg2,
  output logic [DATA_W-1:0]    readData1,
  output logic [DATA_W-1:0]    readData2,
  output logic [DATA_W-1:0]    wbDataOut,
  output logic                 wbWriteOut,
  output logic [REG_AW-1:0]    wbDestOut
);

  wb_ctl_t ctl;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [REG_AW-1:0] rdAddr [2];
  logic [DATA_W-1:0] rdData [2];

  assign ctl = decodeCtl(controlIn);

  wb_mux #(.DATA_W(DATA_W), .LINK_OFS(LINK_OFS)) u_mux (
    .wbSel     (ctl.wbSel),
    .aluResult (aluResultIn),
    .memData   (memDataIn),
    .pc        (pcIn),
    .wbData    (wbDataOut)
  );

  assign wbWriteOut = ctl.regWrite && (ctl.wbSel != WB_SEL_RSV) && (destRegIn != REG_ZERO);
  assign wbDestOut  = destRegIn;

  // r0 is excluded from wbWriteOut, so it only ever holds its reset value.
  always_ff @(posedge clk) begin
    if (rst)             regs <= '0;
    else if (wbWriteOut) regs[destRegIn] <= wbDataOut;
  end

  assign rdAddr[0] = readReg1;
  assign rdAddr[1] = readReg2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit;
`ifdef WB_BYPASS_EN
    assign hit = wbWriteOut && (rdAddr[p] == destRegIn);
`else
    assign hit = 1'b0;
`endif
    // Explicit zero for r0 also covers the pre-reset window when the array is unknown.
    assign rdData[p] = (rst || rdAddr[p] == REG_ZERO) ? '0 :
                       hit                            ? wbDataOut :
                                                        regs[rdAddr[p]];
  end

  assign readData1 = rdData[0];
  assign readData2 = rdData[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed cases then random traffic against a reference array.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:2]  controlIn;
  logic [31:0] pcIn, memDataIn, aluResultIn;
  logic [4:0]  destRegIn, readReg1, readReg2;
  logic [31:0] readData1, readData2, wbDataOut;
  logic        wbWriteOut;
  logic [4:0]  wbDestOut;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .controlIn(controlIn), .pcIn(pcIn), .memDataIn(memDataIn),
    .aluResultIn(aluResultIn), .destRegIn(destRegIn), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .wbDataOut(wbDataOut),
    .wbWriteOut(wbWriteOut), .wbDestOut(wbDestOut)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd1, rd2, wbd;
    logic        wbw;
    logic [4:0]  dst;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] refRegs [32];
  int          errors = 0;
  int          checks = 0;
  bit          done = 0;

  function automatic logic [31:0] refRead(input logic [4:0] a, input logic r,
                                          input logic we, input logic [4:0] d, input logic [31:0] v);
    if (r || a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && a == d) return v;
`endif
    return refRegs[a];
  endfunction

  task automatic step(input string tag, input logic r, input logic [2:0] ctl, input logic [4:0] d,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    logic [31:0] v;
    logic we;
    @(posedge clk);
    #1;
    rst = r; controlIn = ctl; destRegIn = d; aluResultIn = alu; memDataIn = mem; pcIn = pc;
    readReg1 = a1; readReg2 = a2;
    // ctl written as {regWrite, wbSel} literal.
    case (ctl[1:0])
      2'd1:    v = mem;
      2'd2:    v = pc;
      default: v = alu;
    endcase
    we = ctl[2] && ctl[1:0] != 2'd3 && d != 0;
    e.tag = tag; e.wbd = v; e.wbw = we; e.dst = d;
    e.rd1 = refRead(a1, r, we, d, v);
    e.rd2 = refRead(a2, r, we, d, v);
    sbq.push_back(e);
    if (r) foreach (refRegs[i]) refRegs[i] = 32'h0;
    else if (we) refRegs[d] = v;
  endtask

  task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp(e.tag, "readData1", readData1, e.rd1);
        cmp(e.tag, "readData2", readData2, e.rd2);
        cmp(e.tag, "wbDataOut", wbDataOut, e.wbd);
        cmp(e.tag, "wbWriteOut", {31'b0, wbWriteOut}, {31'b0, e.wbw});
        cmp(e.tag, "wbDestOut", {27'b0, wbDestOut}, {27'b0, e.dst});
      end
    end
  end

  initial begin
    logic [4:0] d, a1, a2;
    logic       r;
    foreach (refRegs[i]) refRegs[i] = 32'h0;
    rst = 1; controlIn = 3'b000; destRegIn = 0; aluResultIn = 0; memDataIn = 0; pcIn = 0;
    readReg1 = 0; readReg2 = 0;

    // Reset, with a write presented during reset that must be dropped.
    step("rst_wr", 1, 3'b100, 5'd7, 32'hCAFEF00D, 0, 0, 5'd7, 5'd1);
    for (int i = 1; i < 32; i += 2)
      step("rst_rd", 0, 3'b000, 0, 0, 0, 0, 5'(i), 5'(i + 1));

    step("alu_wr", 0, 3'b100, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0);
    step("alu_rd", 0, 3'b000, 0, 0, 0, 0, 5'd5, 5'd5);
    step("mem_wr", 0, 3'b101, 5'd8, 32'hFFFFFFFF, 32'h12345678, 0, 5'd8, 5'd5);
    step("lnk_wr", 0, 3'b110, 5'd31, 32'h1, 32'h2, 32'h00400010, 5'd8, 5'd31);
    step("lnk_rd", 0, 3'b000, 0, 0, 0, 0, 5'd31, 5'd8);
    step("r0_wr", 0, 3'b100, 5'd0, 32'h55, 0, 0, 5'd0, 5'd0);
    step("r0_rd", 0, 3'b000, 0, 0, 0, 0, 5'd0, 5'd31);
    step("r3_set", 0, 3'b100, 5'd3, 32'h33, 0, 0, 5'd3, 5'd3);
    step("rsv_wr", 0, 3'b111, 5'd3, 32'h77, 0, 0, 5'd3, 5'd3);
    step("rsv_rd", 0, 3'b000, 0, 0, 0, 0, 5'd3, 5'd3);
    step("r9_old", 0, 3'b100, 5'd9, 32'h1, 0, 0, 5'd9, 5'd9);
    step("r9_same", 0, 3'b100, 5'd9, 32'hA5A5A5A5, 0, 0, 5'd9, 5'd9);
    step("r9_next", 0, 3'b000, 0, 0, 0, 0, 5'd9, 5'd9);
    step("b2b_1", 0, 3'b100, 5'd4, 32'h1, 0, 0, 5'd4, 5'd2);
    step("b2b_2", 0, 3'b100, 5'd4, 32'h2, 0, 0, 5'd4, 5'd4);
    step("bubble", 0, 3'b000, 5'd4, 32'h9, 0, 0, 5'd4, 5'd4);
    step("b2b_rd", 0, 3'b000, 0, 0, 0, 0, 5'd4, 5'd4);

    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 99) < 3);
      d  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step("rand", r, 3'($urandom_range(0, 7)), d, $urandom, $urandom, $urandom, a1, a2);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
